// File: rtl/locker_pkg.sv
// -----------------------------------------------------------------------------
// locker_pkg
//   Shared definitions for the locker code checker slice: FSM state encoding,
//   default configuration constants and a small constant helper.
// -----------------------------------------------------------------------------
package locker_pkg;

    // Default configuration (overridable per instance)
    localparam int          DIGITS   = 4;        // code length in digits
    localparam int          DIG_W    = 4;        // bits per digit
    localparam logic [15:0] PWD_INIT = 16'h1234; // first digit in the MSBs
    localparam int          MAX_FAIL = 3;        // mismatches before lockout
    localparam int          OPEN_CYC = 8;        // cycles the lock stays open
    localparam int          LOCK_CYC = 16;       // cycles of lockout

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_OPEN,
        ST_FAIL,
        ST_LOCKOUT
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/locker_if.sv
// -----------------------------------------------------------------------------
// locker_if
//   Keypad digit stream between the keypad encoder (master) and the code
//   checker (slave).
//   key_valid  master->slave  a digit is presented
//   key_digit  master->slave  digit value
//   key_clear  master->slave  discard the partially entered code
//   key_ready  slave->master  checker can accept a digit
// -----------------------------------------------------------------------------
interface locker_if #(
    parameter int DIG_W = locker_pkg::DIG_W
);
    logic             key_valid;
    logic [DIG_W-1:0] key_digit;
    logic             key_clear;
    logic             key_ready;

    modport master (
        output key_valid,
        output key_digit,
        output key_clear,
        input  key_ready
    );

    modport slave (
        input  key_valid,
        input  key_digit,
        input  key_clear,
        output key_ready
    );
endinterface

// File: rtl/locker_timer.sv
// -----------------------------------------------------------------------------
// locker_timer
//   Loadable down-counter shared by the OPEN and LOCKOUT phases. Loading N
//   gives N+1 cycles until done, because done is high while the count is zero.
//   clk, rst   clock, asynchronous active-high reset
//   load       load load_val on this edge (takes priority over counting)
//   load_val   value to load
//   done       count has reached zero
// -----------------------------------------------------------------------------
module locker_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/locker_code_checker.sv
// -----------------------------------------------------------------------------
// locker_code_checker
//   Collects a fixed-length keypad code, compares it with the stored password
//   and drives the unlock pulse, the mismatch error pulse and the lockout alarm.
//   clk, rst     clock, asynchronous active-high reset
//   key_if       keypad digit stream (slave side)
//   pwd_we       password write strobe, honoured only while open
//   pwd_in       new password
//   unlocked     lock open (OPEN_CYC cycles)
//   err          one-cycle mismatch pulse
//   alarm        lockout active (LOCK_CYC cycles)
//   entered_cnt  digits collected so far
//   fail_cnt     consecutive mismatches
// -----------------------------------------------------------------------------
module locker_code_checker
    import locker_pkg::*;
#(
    parameter int                      DIGITS   = locker_pkg::DIGITS,
    parameter int                      DIG_W    = locker_pkg::DIG_W,
    parameter logic [DIGITS*DIG_W-1:0] PWD_INIT = locker_pkg::PWD_INIT,
    parameter int                      MAX_FAIL = locker_pkg::MAX_FAIL,
    parameter int                      OPEN_CYC = locker_pkg::OPEN_CYC,
    parameter int                      LOCK_CYC = locker_pkg::LOCK_CYC
) (
    input  logic                    clk,
    input  logic                    rst,
    locker_if.slave                 key_if,
    input  logic                    pwd_we,
    input  logic [DIGITS*DIG_W-1:0] pwd_in,
    output logic                    unlocked,
    output logic                    err,
    output logic                    alarm,
    output logic [3:0]              entered_cnt,
    output logic [2:0]              fail_cnt
);

    localparam int CODE_W = DIGITS * DIG_W;
    localparam int TMR_W  = $clog2(max_int(OPEN_CYC, LOCK_CYC)) + 1;

    state_t              state, state_next;
    logic [CODE_W-1:0]   code_sr;
    logic [CODE_W-1:0]   pwd;
    logic                accept;
    logic                last_digit;
    logic                match;
    logic                lockout_now;
    logic                tmr_load;
    logic [TMR_W-1:0]    tmr_load_val;
    logic                tmr_done;

    // key_ready is decoded from state and forced low while reset is held,
    // since the state register already sits at IDLE during reset.
    assign key_if.key_ready = (state == ST_IDLE) && !rst;

    assign accept      = key_if.key_valid && key_if.key_ready && !key_if.key_clear;
    assign last_digit  = accept && (entered_cnt == 4'(DIGITS - 1));
    assign match       = (code_sr == pwd);
    assign lockout_now = ((fail_cnt + 3'd1) >= 3'(MAX_FAIL));

    // The timer is loaded during CHECK so it is already counting on the first
    // cycle of OPEN or LOCKOUT; done on the last cycle releases back to IDLE.
    assign tmr_load     = (state == ST_CHECK);
    assign tmr_load_val = match ? TMR_W'(OPEN_CYC - 1) : TMR_W'(LOCK_CYC - 1);

    locker_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .done     (tmr_done)
    );

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (last_digit) state_next = ST_CHECK;
            ST_CHECK: begin
                if (match)            state_next = ST_OPEN;
                else if (lockout_now) state_next = ST_LOCKOUT;
                else                  state_next = ST_FAIL;
            end
            ST_OPEN:    if (tmr_done) state_next = ST_IDLE;
            ST_FAIL:    state_next = ST_IDLE;
            ST_LOCKOUT: if (tmr_done) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // State and registered outputs; outputs follow the state being entered so
    // they line up with the state itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            unlocked <= 1'b0;
            err      <= 1'b0;
            alarm    <= 1'b0;
        end else begin
            state    <= state_next;
            unlocked <= (state_next == ST_OPEN);
            err      <= (state_next == ST_FAIL);
            alarm    <= (state_next == ST_LOCKOUT);
        end
    end

    // Code collection, failure counting and password storage. The password
    // is reset to PWD_INIT so a power-up lock has a known code.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_sr     <= '0;
            entered_cnt <= '0;
            fail_cnt    <= '0;
            pwd         <= PWD_INIT;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (key_if.key_clear) begin
                        code_sr     <= '0;
                        entered_cnt <= '0;
                    end else if (accept) begin
                        code_sr     <= {code_sr[CODE_W-DIG_W-1:0], key_if.key_digit};
                        entered_cnt <= entered_cnt + 4'd1;
                    end
                end
                ST_CHECK: begin
                    entered_cnt <= '0;
                    if (match) begin
                        fail_cnt <= '0;
                    end else if (fail_cnt != 3'(MAX_FAIL)) begin
                        fail_cnt <= fail_cnt + 3'd1;
                    end
                end
                ST_OPEN: begin
                    if (pwd_we) pwd <= pwd_in;
                end
                ST_LOCKOUT: begin
                    if (tmr_done) fail_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
